// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (A) and LSU (B).
// Latches the winner's request, sequences it to ack or timeout, returns data.
module mem_port_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [31:0] addr_a,
   input  logic        req_b,
   input  logic [31:0] addr_b,
   input  logic [31:0] wdata_b,
   input  logic        we_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        done_a,
   output logic        done_b,
   output logic        err,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_A = 2'd1,
      BUSY_B = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   state_t           state, state_nxt;
   logic             last_b;
   logic [CNT_W-1:0] cnt;
   logic             ea, eb;
   logic             win_a, win_b;
   logic             tmo;

   // A requester still showing its done pulse is masked from this round
   assign ea    = req_a & ~done_a;
   assign eb    = req_b & ~done_b;
   assign win_a = ea & (~eb | last_b);
   assign win_b = eb & (~ea | ~last_b);
   assign tmo   = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (win_a)      state_nxt = BUSY_A;
            else if (win_b) state_nxt = BUSY_B;
         end
         BUSY_A, BUSY_B: begin
            if (mem_ready || tmo) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      mem_req = 1'b0;
      unique case (state)
         BUSY_A: begin
            gnt_a   = 1'b1;
            mem_req = 1'b1;
         end
         BUSY_B: begin
            gnt_b   = 1'b1;
            mem_req = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_a    <= 1'b0;
         done_b    <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         sel       <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         last_b    <= 1'b1;
         cnt       <= '0;
      end else begin
         done_a <= 1'b0;
         done_b <= 1'b0;
         err    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_a) begin
                  mem_addr  <= addr_a;
                  mem_wdata <= '0;
                  mem_we    <= 1'b0;
                  sel       <= 1'b0;
                  last_b    <= 1'b0;
                  cnt       <= '0;
               end else if (win_b) begin
                  mem_addr  <= addr_b;
                  mem_wdata <= wdata_b;
                  mem_we    <= we_b;
                  sel       <= 1'b1;
                  last_b    <= 1'b1;
                  cnt       <= '0;
               end
            end
            BUSY_A, BUSY_B: begin
               if (mem_ready) begin
                  rdata  <= mem_rdata;
                  done_a <= (state == BUSY_A);
                  done_b <= (state == BUSY_B);
               end else if (tmo) begin
                  rdata  <= '0;
                  err    <= 1'b1;
                  done_a <= (state == BUSY_A);
                  done_b <= (state == BUSY_B);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Phases: continuous ties, random traffic with resets, dead memory.
module tb_mem_port_arbiter;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b, we_b;
   logic [31:0] addr_a, addr_b, wdata_b;
   logic        gnt_a, gnt_b, done_a, done_b, err;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        sel, mem_req, mem_we, mem_ready;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(TMO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .addr_a(addr_a),
      .req_b(req_b), .addr_b(addr_b),
      .wdata_b(wdata_b), .we_b(we_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b),
      .done_a(done_a), .done_b(done_b),
      .err(err), .rdata(rdata), .sel(sel),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // Model: owner 0 = nobody, 1 = A, 2 = B; waited = BUSY cycles spent
   int          m_owner;
   int          m_waited;
   bit          m_prev_b;
   bit          m_done_a, m_done_b, m_err, m_we, m_sel, m_was_rst;
   logic [31:0] m_rdata, m_addr, m_wdata;
   int          grants_a, grants_b, timeouts;

   task automatic model_step();
      bit fin;
      m_was_rst = rst;
      if (rst) begin
         m_owner  = 0;
         m_waited = 0;
         m_prev_b = 1;
         m_done_a = 0;
         m_done_b = 0;
         m_err    = 0;
         m_rdata  = 0;
         m_addr   = 0;
         m_wdata  = 0;
         m_we     = 0;
         m_sel    = 0;
         return;
      end
      if (m_owner == 0) begin
         bit wa, wb;
         wa = req_a && !m_done_a;
         wb = req_b && !m_done_b;
         m_done_a = 0;
         m_done_b = 0;
         m_err    = 0;
         if (wa && wb) begin
            wa = m_prev_b;
            wb = !m_prev_b;
         end
         if (wa) begin
            m_owner = 1; m_addr = addr_a;
            m_wdata = 0; m_we = 0; m_sel = 0;
            m_prev_b = 0; m_waited = 0;
            grants_a++;
         end else if (wb) begin
            m_owner = 2; m_addr = addr_b;
            m_wdata = wdata_b; m_we = we_b; m_sel = 1;
            m_prev_b = 1; m_waited = 0;
            grants_b++;
         end
         return;
      end
      fin = 0;
      m_err = 0;
      if (mem_ready) begin
         m_rdata = mem_rdata;
         fin = 1;
      end else if (TMO != 0 && m_waited + 1 == TMO) begin
         m_rdata = 0;
         m_err = 1;
         fin = 1;
         timeouts++;
      end else begin
         m_waited++;
      end
      m_done_a = fin && m_owner == 1;
      m_done_b = fin && m_owner == 2;
      if (fin) m_owner = 0;
   endtask

   task automatic check_all();
      check("gnt_a", gnt_a, m_owner == 1);
      check("gnt_b", gnt_b, m_owner == 2);
      check("gnt_excl", gnt_a & gnt_b, 0);
      check("mem_req", mem_req, m_owner != 0);
      check("done_a", done_a, m_done_a);
      check("done_b", done_b, m_done_b);
      check("err", err, m_err);
      check("sel", sel, m_sel);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("mem_we", mem_we, m_we);
      if (m_done_a || m_done_b || m_was_rst)
         check("rdata", rdata, m_rdata);
   endtask

   initial begin
      int p_req, p_keep, p_rdy, p_rst;
      rst = 1; req_a = 0; req_b = 0; we_b = 0;
      addr_a = 0; addr_b = 0; wdata_b = 0;
      mem_ready = 0; mem_rdata = 0;
      grants_a = 0; grants_b = 0; timeouts = 0;
      model_step();
      for (int cyc = 0; cyc < 2600; cyc++) begin
         @(negedge clk);
         check_all();
         if (cyc < 200) begin
            p_req = 100; p_keep = 100; p_rdy = 100; p_rst = 0;
         end else if (cyc < 1500) begin
            p_req = 30; p_keep = 50; p_rdy = 40; p_rst = 1;
         end else if (cyc < 2300) begin
            p_req = 40; p_keep = 30; p_rdy = 0; p_rst = 0;
         end else begin
            p_req = 50; p_keep = 50; p_rdy = 60; p_rst = 0;
         end
         rst = (cyc < 2) ||
               (p_rst > 0 && $urandom_range(199) < p_rst);
         // Requesters hold until done; in the done cycle they may
         // keep req high with a fresh request (masked this cycle).
         if (!req_a || m_done_a) begin
            if (req_a) req_a = ($urandom_range(99) < p_keep);
            else       req_a = ($urandom_range(99) < p_req);
            if (req_a) addr_a = {$urandom} & 32'hFFFF_FFFC;
         end
         if (!req_b || m_done_b) begin
            if (req_b) req_b = ($urandom_range(99) < p_keep);
            else       req_b = ($urandom_range(99) < p_req);
            if (req_b) begin
               addr_b  = $urandom;
               wdata_b = $urandom;
               we_b    = $urandom_range(1);
            end
         end
         mem_ready = ($urandom_range(99) < p_rdy);
         mem_rdata = $urandom;
         model_step();
      end
      @(negedge clk);
      check_all();
      check("saw_grant_a", grants_a > 20, 1);
      check("saw_grant_b", grants_b > 20, 1);
      check("saw_timeout", timeouts > 5, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single 32-bit memory port between instruction fetch (requester A) and the load/store unit (requester B).
- Performs round-robin arbitration and latches the winner's address, write data and write enable.
- Drives the 2:1 select that steers the winner onto the memory port, and sequences the transaction until the memory acknowledges or a timeout fires.
- Returns read data and a one-cycle completion pulse to the granted requester.

Parameters:
- TIMEOUT, default 16: maximum number of BUSY cycles without mem_ready before the transaction is aborted. 0 disables the timeout.
- CNT_W, default 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- req_a  input  1  fetch request; held until done_a
- addr_a  input  32  fetch address
- req_b  input  1  LSU request; held until done_b
- addr_b  input  32  LSU address
- wdata_b  input  32  LSU store data
- we_b  input  1  LSU write enable (fetch is read-only)
- gnt_a  output  1  A owns the port (state BUSY_A)
- gnt_b  output  1  B owns the port (state BUSY_B)
- done_a  output  1  one-cycle completion pulse to A
- done_b  output  1  one-cycle completion pulse to B
- err  output  1  qualifies the done pulse: 1 = aborted by timeout
- rdata  output  32  registered read data, valid while done_a or done_b is high
- sel  output  1  datapath mux select: 0 = A, 1 = B; registered
- mem_req  output  1  memory request, high throughout BUSY_A and BUSY_B
- mem_addr  output  32  latched address of the owner
- mem_wdata  output  32  latched store data (0 when A owns the port)
- mem_we  output  1  latched write enable (0 when A owns the port)
- mem_ready  input  1  memory acknowledge; sampled only in BUSY states
- mem_rdata  input  32  memory read data, valid with mem_ready

Behaviour:
- Reset (rst=1 at an edge, including mid-transaction): state <= IDLE.
  - gnt_a, gnt_b, done_a, done_b, err, mem_req, mem_we, sel = 0.
  - rdata, mem_addr, mem_wdata = 0. Counter = 0.
  - last_b = 1, so A wins the first tie.
  - Any in-flight transaction is dropped; no done pulse is issued.
- States: IDLE, BUSY_A, BUSY_B.
- Masking in IDLE: a requester whose done pulse is high this cycle is masked from arbitration, so a requester that is slow to drop req is not re-granted.
- IDLE, with effective requests ea = req_a & ~done_a and eb = req_b & ~done_b:
  - ea & eb: grant A if last_b=1, otherwise grant B.
  - ea only: grant A. eb only: grant B. Neither: stay in IDLE.
  - On a grant, at the edge: latch the winner's addr (plus wdata and we for B, zeros for A); sel <= winner; last_b <= (winner==B); counter <= 0; move to BUSY_x.
- BUSY_x:
  - mem_req = 1; gnt_x = 1.
  - mem_ready=1: rdata <= mem_rdata, err <= 0, done_x <= 1 for the next cycle, state <= IDLE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: done_x <= 1, err <= 1, rdata <= 0, state <= IDLE.
  - Else: counter increments.
- done_x and err are high for exactly one cycle, in IDLE, and clear at the following edge.
- Latency: request sampled in IDLE at edge N → mem_req from cycle N+1. Zero-wait memory (mem_ready in the first BUSY cycle) → done in cycle N+2.
- A request rising in the done cycle of the other requester is arbitrated in that same IDLE cycle (back-to-back, no bubble).
- Requests dropped while BUSY do not abort the transaction.
- sel, mem_addr, mem_wdata and mem_we are stable for the whole BUSY period. They hold their values in IDLE; mem_req=0 qualifies them.
- mem_ready is ignored in IDLE.
- gnt_a and gnt_b are never both 1.

Test Plan:
- Single fetch: req_a=1, addr_a=0x0000_0040, mem_ready=1 in the first BUSY cycle, mem_rdata=0x0051_0093 → gnt_a and mem_req high 1 cycle, sel=0, mem_addr=0x40, done_a with rdata=0x0051_0093 two cycles after the request edge, err=0.
- Simultaneous requests after reset: req_a=req_b=1 held continuously, zero-wait memory → grants alternate A, B, A, B. The masked requester is never re-granted during its own done cycle.
- LSU store: req_b=1, addr_b=0x1000_0008, wdata_b=0xDEAD_BEEF, we_b=1, mem_ready after 3 wait cycles → sel=1, mem_we=1, mem_wdata=0xDEAD_BEEF held for 4 BUSY cycles; then done_b=1, err=0.
- Timeout: TIMEOUT=16, req_a=1, mem_ready tied low → exactly 16 BUSY cycles, then done_a=1, err=1, rdata=0. The next request is granted normally.
- Reset mid-operation: rst=1 in the 2nd BUSY_B cycle → next cycle IDLE, mem_req=0, no done_b. The first tie after reset goes to A.
- Ignored ready: mem_ready pulsed while IDLE with no requests → no state change, no done pulse, outputs unchanged.
